// File: rtl/mole_scheduler_if.sv
// Game-side bundle for the mole scheduler: the game level, whack pulses in,
// and the lit mask plus score/miss counters out.
interface mole_scheduler_if #(
    parameter int WIDTH   = 18,
    parameter int SCORE_W = 8
);
    logic               game_active;
    logic [WIDTH-1:0]   hit_pulse;
    logic [WIDTH-1:0]   active_mask;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] miss_count;

    modport master (
        output game_active,
        output hit_pulse,
        input  active_mask,
        input  score,
        input  miss_count
    );

    modport slave (
        input  game_active,
        input  hit_pulse,
        output active_mask,
        output score,
        output miss_count
    );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: lights one LFSR-chosen mole at a time, scores hits and
// timeouts. Define MOLE_SPEEDUP_EN to shorten the on-time every fourth hit.
//
// state | meaning
// IDLE  | no game; mask dark, counters hold last game's result
// PICK  | drawing a random index until one lands inside WIDTH
// ON    | one mole lit, waiting for a hit or the on-time to expire
// GAP   | dark pause before the next pick
module mole_scheduler #(
    parameter int WIDTH      = 18,
    parameter int ON_CYCLES  = 50_000_000,
    parameter int GAP_CYCLES = 25_000_000,
    parameter int SCORE_W    = 8
) (
    input logic             clk,
    input logic             rst_n,
    mole_scheduler_if.slave bus
);
    localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0]   ON_FULL   = CNT_W'(ON_CYCLES);
    localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [5:0]         WIDTH_6   = 6'(WIDTH);

    typedef enum logic [1:0] {IDLE, PICK, ON, GAP} state_t;

    state_t             state;
    logic [15:0]        lfsr;
    logic [CNT_W-1:0]   cnt;
    logic               game_d;
    logic [WIDTH-1:0]   mask_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] miss_q;

    logic               lfsr_fb;
    logic [4:0]         idx;
    logic               hit;
    logic               game_rise;
    logic [SCORE_W-1:0] score_inc;
    logic [SCORE_W-1:0] miss_inc;
    logic [CNT_W-1:0]   on_load;

    assign lfsr_fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign idx       = lfsr[4:0];
    assign hit       = |(bus.hit_pulse & mask_q);
    assign game_rise = bus.game_active & ~game_d;
    assign score_inc = (score_q == SCORE_MAX) ? score_q : score_q + 1'b1;
    assign miss_inc  = (miss_q == SCORE_MAX) ? miss_q : miss_q + 1'b1;

`ifdef MOLE_SPEEDUP_EN
    localparam logic [CNT_W-1:0] ON_STEP  = CNT_W'(ON_CYCLES / 8);
    localparam logic [CNT_W-1:0] ON_FLOOR = CNT_W'(ON_CYCLES / 4);

    logic [CNT_W-1:0] on_time;
    logic             speed_step;

    // Only a real increment counts; a saturated score never speeds things up.
    assign speed_step = (state == ON) && bus.game_active && hit &&
                        (score_q != SCORE_MAX) && (score_inc[1:0] == 2'b00);
    assign on_load    = on_time - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_time <= ON_FULL;
        end else if ((state == IDLE) && bus.game_active && game_rise) begin
            on_time <= ON_FULL;
        end else if (speed_step) begin
            if (on_time >= ON_FLOOR + ON_STEP) begin
                on_time <= on_time - ON_STEP;
            end else begin
                on_time <= ON_FLOOR;
            end
        end
    end
`else
    assign on_load = ON_FULL - 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lfsr    <= 16'hACE1;
            cnt     <= '0;
            game_d  <= 1'b1;
            mask_q  <= '0;
            score_q <= '0;
            miss_q  <= '0;
        end else begin
            lfsr   <= {lfsr_fb, lfsr[15:1]};
            game_d <= bus.game_active;
            if (!bus.game_active) begin
                state  <= IDLE;
                mask_q <= '0;
                cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (game_rise) begin
                            score_q <= '0;
                            miss_q  <= '0;
                            state   <= PICK;
                        end
                    end
                    PICK: begin
                        if ({1'b0, idx} < WIDTH_6) begin
                            mask_q <= WIDTH'(1) << idx;
                            cnt    <= on_load;
                            state  <= ON;
                        end
                    end
                    ON: begin
                        // A hit on the last lit cycle wins over the timeout.
                        if (hit) begin
                            score_q <= score_inc;
                            mask_q  <= '0;
                            cnt     <= GAP_LOAD;
                            state   <= GAP;
                        end else if (cnt == '0) begin
                            miss_q <= miss_inc;
                            mask_q <= '0;
                            cnt    <= GAP_LOAD;
                            state  <= GAP;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    GAP: begin
                        if (cnt == '0) begin
                            state <= PICK;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.active_mask = mask_q;
    assign bus.score       = score_q;
    assign bus.miss_count  = miss_q;
endmodule
